// File: rtl/cpu_defs.sv
// cpu_defs: shared branch resolve/update types, queue sizing defaults and counter helper.
package cpu_defs;
  typedef enum logic [1:0] {CF_BRANCH, CF_JUMP, CF_CALL, CF_RET} cf_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
    logic [1:0]  counter;
    cf_t         cf;
  } branch_resolved_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  counter;
    cf_t         cf;
  } branch_update_t;
  localparam int BRQ_LANES = 2;
  localparam int BRQ_DEPTH = 4;
  function automatic logic [1:0] sat_counter(input logic taken, input logic [1:0] c);
    return taken ? (c == 2'd3 ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/multi_push_fifo.sv
// multi_push_fifo: FIFO accepting up to PUSH_PORTS writes per cycle, packed in port order.
module multi_push_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PUSH_PORTS = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PUSH_PORTS-1:0]               push,
  input  logic [PUSH_PORTS-1:0][WIDTH-1:0]    push_data,
  input  logic                                pop,
  output logic [WIDTH-1:0]                    head,
  output logic [$clog2(DEPTH):0]              count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] slot [PUSH_PORTS];
  logic [AW:0] n_push;
  always_comb begin
    n_push = '0;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      slot[i] = wr_ptr + n_push[AW-1:0];
      n_push = n_push + (AW+1)'(push[i]);
    end
  end
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < PUSH_PORTS; i++)
        if (push[i]) mem[slot[i]] <= push_data[i];
      wr_ptr <= wr_ptr + n_push[AW-1:0];
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + n_push - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: filters resolved lanes behind the oldest mispredict, queues predictor
// updates all-or-nothing and issues a one-cycle fetch redirect.
module branch_resolve_queue
  import cpu_defs::*;
#(
  parameter int LANES = BRQ_LANES,
  parameter int DEPTH = BRQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  branch_resolved_t [LANES-1:0]  resolved,
  input  logic                          flush,
  output logic                          stall_req,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_pc,
  output logic                          upd_valid,
  output branch_update_t                upd,
  input  logic                          upd_ready
);
  localparam int UW = $bits(branch_update_t);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [LANES-1:0] live, push;
  logic [LANES-1:0][UW-1:0] push_data;
  logic [CW-1:0] count, need;
  logic [UW-1:0] head;
  logic seen, arm;
  logic [31:0] next_pc;
  always_comb begin
    seen = 1'b0;
    arm = 1'b0;
    need = '0;
    next_pc = '0;
    live = '0;
    push_data = '0;
    for (int i = 0; i < LANES; i++) begin
      // once the oldest mispredict is seen, every younger lane is wrong-path
      live[i] = resolved[i].valid & ~flush & ~seen;
      need = need + CW'(live[i]);
      if (live[i] & resolved[i].mispredict) begin
        seen = 1'b1;
        arm = 1'b1;
        next_pc = resolved[i].taken ? resolved[i].target : resolved[i].pc + 32'd8;
      end
      push_data[i] = {resolved[i].pc, resolved[i].target, resolved[i].taken,
                      sat_counter(resolved[i].taken, resolved[i].counter), resolved[i].cf};
    end
    stall_req = need > CW'(DEPTH) - count;
    push = stall_req ? '0 : live;
  end
  assign upd_valid = count != '0;
  assign upd = branch_update_t'(head);
  multi_push_fifo #(.WIDTH(UW), .DEPTH(DEPTH), .PUSH_PORTS(LANES)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(push_data),
    .pop(upd_valid & upd_ready),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_valid <= arm & ~stall_req;
      if (arm & ~stall_req) redirect_pc <= next_pc;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scenarios checked against a queue-based scoreboard.
module tb_branch_resolve_queue;
  import cpu_defs::*;
  localparam int LANES = BRQ_LANES;
  localparam int DEPTH = BRQ_DEPTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic upd_ready = 1'b0;
  branch_resolved_t [LANES-1:0] lanes = '0;
  logic stall_req, redirect_valid, upd_valid;
  logic [31:0] redirect_pc;
  branch_update_t upd;
  branch_update_t q[$];
  logic [31:0] last_pc = '0;
  int checks = 0;
  int failures = 0;

  branch_resolve_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .resolved(lanes), .flush(flush), .stall_req(stall_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd(upd), .upd_ready(upd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic branch_resolved_t br(input logic v, input logic [31:0] pc,
      input logic [31:0] tgt, input logic tk, input logic mp, input logic [1:0] c);
    branch_resolved_t b;
    b = '{valid: v, pc: pc, target: tgt, taken: tk, mispredict: mp, counter: c, cf: CF_BRANCH};
    return b;
  endfunction

  function automatic branch_update_t mk_upd(input branch_resolved_t b);
    branch_update_t u;
    int v;
    v = int'(b.counter) + (b.taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    u = '{pc: b.pc, target: b.target, taken: b.taken, counter: 2'(v), cf: b.cf};
    return u;
  endfunction

  // inputs are already set at a negedge; check this cycle, then check the registered redirect
  task automatic tick();
    branch_update_t e[$];
    logic seen, hm, stall, pop_now;
    int need;
    logic [31:0] npc;
    seen = 0; hm = 0; need = 0; npc = '0;
    #1;
    for (int i = 0; i < LANES; i++)
      if (lanes[i].valid && !flush && !seen) begin
        e.push_back(mk_upd(lanes[i]));
        need++;
        if (lanes[i].mispredict) begin
          seen = 1; hm = 1;
          npc = lanes[i].taken ? lanes[i].target : lanes[i].pc + 32'd8;
        end
      end
    stall = need > DEPTH - q.size();
    chk("stall_req", stall_req, stall);
    chk("upd_valid", upd_valid, q.size() != 0);
    if (q.size() != 0) chk("upd_head", upd, q[0]);
    pop_now = q.size() != 0 && upd_ready;
    if (!stall) foreach (e[k]) q.push_back(e[k]);
    if (pop_now) void'(q.pop_front());
    @(negedge clk);
    chk("redirect_valid", redirect_valid, hm && !stall);
    if (hm && !stall) last_pc = npc;
    chk("redirect_pc", redirect_pc, last_pc);
  endtask

  task automatic idle(input int n, input logic rdy);
    lanes = '0; flush = 0; upd_ready = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0; lanes = '0; flush = 0; upd_ready = 0;
    q.delete(); last_pc = '0;
    #1;
    chk("rst_upd_valid", upd_valid, 1'b0);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_stall", stall_req, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    // taken mispredict redirects to target; younger lane dropped
    upd_ready = 0;
    lanes[0] = br(1, 32'h1000, 32'h1040, 1, 1, 2'd3);
    lanes[1] = br(1, 32'h1004, 32'h1100, 0, 0, 2'd1);
    tick();
    chk("redir_1040", redirect_pc, 32'h1040);
    chk("entry_ctr3", upd.counter, 2'd3);
    idle(2, 1);
    // not-taken mispredict skips the delay slot
    lanes[0] = br(1, 32'h2000, 32'h2100, 0, 1, 2'd2);
    lanes[1] = br(1, 32'h2004, 32'h2200, 1, 0, 2'd1);
    upd_ready = 0;
    tick();
    chk("redir_2008", redirect_pc, 32'h2008);
    chk("entry_ctr1", upd.counter, 2'd1);
    idle(1, 1);
    idle(1, 0);
    chk("count1_drained", upd_valid, 1'b0);
    // fill to 3 then offer 2 live lanes: stall, no push, no redirect
    lanes[1] = '0;
    lanes[0] = br(1, 32'h3000, 32'h3010, 1, 0, 2'd1); tick();
    lanes[0] = br(1, 32'h3004, 32'h3014, 0, 0, 2'd0); tick();
    lanes[0] = br(1, 32'h3008, 32'h3018, 1, 0, 2'd3); tick();
    lanes[0] = br(1, 32'h300c, 32'h301c, 0, 0, 2'd2);
    lanes[1] = br(1, 32'h3010, 32'h3020, 1, 1, 2'd0);
    upd_ready = 1;
    tick();
    chk("stall_no_redirect", redirect_valid, 1'b0);
    idle(1, 0);
    chk("count2_after_pop", q.size(), 2);
    idle(3, 1);
    // nine single pushes with concurrent pops wrap both pointers
    upd_ready = 1;
    for (int k = 0; k < 9; k++) begin
      lanes[0] = br(1, 32'h4000 + 32'(k * 4), 32'h5000, 0, 0, 2'd0);
      lanes[1] = '0;
      tick();
    end
    idle(2, 1);
    // flush squashes the mispredict lane but the queue still drains
    lanes[0] = br(1, 32'h6000, 32'h6100, 1, 0, 2'd1); upd_ready = 0; tick();
    lanes[0] = br(1, 32'h6004, 32'h6104, 0, 0, 2'd1); tick();
    lanes[0] = br(1, 32'h6008, 32'h6200, 1, 1, 2'd0);
    flush = 1; upd_ready = 1;
    tick();
    chk("flush_no_redirect", redirect_valid, 1'b0);
    idle(3, 1);
    // reset mid-stream beats a pending push and redirect
    lanes[0] = br(1, 32'h7000, 32'h7100, 1, 0, 2'd2); upd_ready = 0; tick();
    lanes[0] = br(1, 32'h7004, 32'h7104, 0, 0, 2'd2); tick();
    chk("pre_rst_count2", q.size(), 2);
    lanes[0] = br(1, 32'h7008, 32'h7300, 1, 1, 2'd1);
    do_reset();
    idle(2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
